// File: rtl/mem_1_half_if.sv
// mem_1_half_if: req/ack data-bus between the MEM first half (master) and memory (slave).
interface mem_1_half_if;
  logic        dreq;
  logic        dwe;
  logic [31:0] daddr;
  logic [3:0]  dbe;
  logic [31:0] dwdata;
  logic        dack;
  modport master (output dreq, dwe, daddr, dbe, dwdata, input dack);
  modport slave  (input dreq, dwe, daddr, dbe, dwdata, output dack);
endinterface

// File: rtl/mem_1_half.sv
// mem_1_half: MEM first half - load/store decode, alignment check, req/ack bus transaction, MMID register.
// Optional MEM_TIMEOUT_EN: abort a REQ that sees no dack within TIMEOUT cycles with a bus-error code.
module mem_1_half #(
  parameter int TIMEOUT = 16,
  parameter int EXC_W = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      IR_M,
  input  logic [31:0]      PC8_M,
  input  logic [31:0]      ALUOUT_M,
  input  logic [31:0]      RT_M,
  input  logic [31:0]      XALUOUT_M,
  input  logic [EXC_W-1:0] EXC_M,
  input  logic             flush,
  output logic [31:0]      IR_MMID,
  output logic [31:0]      PC8_MMID,
  output logic [31:0]      ALUOUT_MMID,
  output logic [31:0]      RT_MMID,
  output logic [31:0]      XALUOUT_MMID,
  output logic [EXC_W-1:0] EXC_MMID,
  output logic             stall_mem,
  mem_1_half_if.master     bus
);
  typedef enum logic {IDLE, REQ} state_t;
  state_t state, state_n;
  logic [5:0] op;
  logic [1:0] a;
  logic is_st, is_mem, is_w, is_h, misal, go, done, tmo, take, kill;
  logic [EXC_W-1:0] exc, exc_n;
  logic [3:0] be, dbe_q;
  logic [31:0] wd, daddr_q, dwdata_q;
  logic dreq_q, dwe_q;
  assign op = IR_M[31:26];
  assign a = ALUOUT_M[1:0];
  assign is_st = op inside {6'h28, 6'h29, 6'h2b};
  assign is_mem = is_st || op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25};
  assign is_w = op inside {6'h23, 6'h2b};
  assign is_h = op inside {6'h21, 6'h25, 6'h29};
  assign misal = is_w ? |a : is_h && a[0];
  assign exc = |EXC_M ? EXC_M : misal ? (is_st ? EXC_W'(5) : EXC_W'(4)) : '0;
  assign go = is_mem && exc == '0 && !flush;
  assign be = is_w ? 4'b1111 : is_h ? (a[1] ? 4'b1100 : 4'b0011) : 4'b0001 << a;
  assign wd = is_w ? RT_M : is_h ? {2{RT_M[15:0]}} : {4{RT_M[7:0]}};
  assign done = bus.dack || tmo;
`ifdef MEM_TIMEOUT_EN
  logic [7:0] cnt;
  always_ff @(posedge clk) cnt <= reset || state == IDLE ? 8'd0 : cnt + {7'd0, !bus.dack};
  assign tmo = !bus.dack && cnt == 8'(TIMEOUT - 1);
`else
  assign tmo = TIMEOUT < 0;
`endif
  always_ff @(posedge clk) state <= reset ? IDLE : state_n;
  always_comb begin
    state_n = state;
    stall_mem = 1'b0;
    take = 1'b0;
    exc_n = exc;
    if (state == IDLE) begin
      state_n = go ? REQ : IDLE;
      stall_mem = go;
      take = !go && !flush;
    end else begin
      state_n = done ? IDLE : REQ;
      stall_mem = !done;
      take = done && !kill && !flush;
      exc_n = bus.dack ? '0 : EXC_W'(7);
    end
    if (reset) stall_mem = 1'b0;
  end
  // Anything not loading the M values loads an all-zero bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      {IR_MMID, PC8_MMID, ALUOUT_MMID, RT_MMID, XALUOUT_MMID, EXC_MMID} <= '0;
      {dreq_q, dwe_q, daddr_q, dbe_q, dwdata_q, kill} <= '0;
    end else begin
      {IR_MMID, PC8_MMID, ALUOUT_MMID, RT_MMID, XALUOUT_MMID, EXC_MMID} <=
        take ? {IR_M, PC8_M, ALUOUT_M, RT_M, XALUOUT_M, exc_n} : '0;
      kill <= state == REQ && !done && (kill || flush);
      if (state == IDLE && go) begin
        dreq_q <= 1'b1;
        dwe_q <= is_st;
        daddr_q <= {ALUOUT_M[31:2], 2'b00};
        dbe_q <= be;
        dwdata_q <= wd;
      end else if (state == REQ && done) begin
        dreq_q <= 1'b0;
        dwe_q <= 1'b0;
      end
    end
  end
  assign bus.dreq = dreq_q;
  assign bus.dwe = dwe_q;
  assign bus.daddr = daddr_q;
  assign bus.dbe = dbe_q;
  assign bus.dwdata = dwdata_q;
endmodule
